// File: rtl/line_buffer_2taps_if.sv
// rtl/line_buffer_2taps_if.sv - raster stream in, two-line tap bundle out
interface line_buffer_2taps_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] shiftin;
  logic                  shiftin_valid;
  logic                  shiftin_hs;
  logic                  shiftin_vs;
  logic [DATA_WIDTH-1:0] taps1x;
  logic [DATA_WIDTH-1:0] taps0x;
  logic [DATA_WIDTH-1:0] shiftout;
  logic                  tap1_ok;
  logic                  tap0_ok;
  logic                  overrun;

  modport master (
    output shiftin, shiftin_valid, shiftin_hs, shiftin_vs,
    input  taps1x, taps0x, shiftout, tap1_ok, tap0_ok, overrun
  );

  modport slave (
    input  shiftin, shiftin_valid, shiftin_hs, shiftin_vs,
    output taps1x, taps0x, shiftout, tap1_ok, tap0_ok, overrun
  );
endinterface

// File: rtl/line_buffer_2taps.sv
// rtl/line_buffer_2taps.sv - two-line pixel delay with zero-latency taps
module line_buffer_2taps #(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_WIDTH = 640,
  parameter int ADDR_WIDTH = 10
) (
  input logic                clk,
  input logic                reset_p,
  line_buffer_2taps_if.slave bus
);
  // One spare bit so col_cnt can park at LINE_WIDTH once a line overruns.
  localparam int CW = ADDR_WIDTH + 1;
  localparam int IW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [CW-1:0] LW_C = CW'(LINE_WIDTH);

  logic [DATA_WIDTH-1:0] store1 [LINE_WIDTH];
  logic [DATA_WIDTH-1:0] store0 [LINE_WIDTH];

  logic [CW-1:0] col_cnt;
  logic [1:0]    line_cnt;
  logic [1:0]    line_inc;
  logic          hs_d;
  logic          tap1_ok_r;
  logic          tap0_ok_r;
  logic          overrun_r;

  logic          qual;
  logic          in_range;
  logic          wr_en;
  logic          hs_fall;
  logic [IW-1:0] addr;

  assign qual     = bus.shiftin_valid && bus.shiftin_hs && bus.shiftin_vs;
  assign in_range = (col_cnt < LW_C);
  assign wr_en    = !reset_p && qual && in_range;
  assign hs_fall  = hs_d && !bus.shiftin_hs;
  assign addr     = in_range ? col_cnt[IW-1:0] : '0;
  assign line_inc = (line_cnt == 2'd2) ? 2'd2 : line_cnt + 2'd1;

  // Each column shifts down one row: new pixel into store1, old row1 into store0.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      store1[addr] <= bus.shiftin;
      store0[addr] <= store1[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      col_cnt   <= '0;
      line_cnt  <= 2'd0;
      hs_d      <= 1'b0;
      tap1_ok_r <= 1'b0;
      tap0_ok_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      hs_d <= bus.shiftin_hs;
      if (!bus.shiftin_vs) begin
        col_cnt   <= '0;
        line_cnt  <= 2'd0;
        tap1_ok_r <= 1'b0;
        tap0_ok_r <= 1'b0;
        overrun_r <= 1'b0;
      end else if (!bus.shiftin_hs) begin
        col_cnt <= '0;
        // Empty lines do not count, so taps never point at an unwritten row.
        if (hs_fall && col_cnt != '0) begin
          line_cnt  <= line_inc;
          tap1_ok_r <= 1'b1;
          tap0_ok_r <= (line_inc == 2'd2);
        end
      end else if (qual) begin
        if (in_range) begin
          col_cnt <= col_cnt + CW'(1);
        end else begin
          overrun_r <= 1'b1;
        end
      end
    end
  end

  assign bus.taps1x   = (tap1_ok_r && in_range) ? store1[addr] : '0;
  assign bus.taps0x   = (tap0_ok_r && in_range) ? store0[addr] : '0;
  assign bus.shiftout = bus.taps0x;
  assign bus.tap1_ok  = tap1_ok_r;
  assign bus.tap0_ok  = tap0_ok_r;
  assign bus.overrun  = overrun_r;
endmodule

// File: tb/tb_line_buffer_2taps.sv
// tb/tb_line_buffer_2taps.sv - directed bench for line_buffer_2taps
module tb_line_buffer_2taps;
  logic clk = 1'b0;
  logic reset_p = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [26:0] obs;
  logic [26:0] exp_v;

  line_buffer_2taps_if #(.DATA_WIDTH(8)) bus ();

  line_buffer_2taps #(
    .DATA_WIDTH(8),
    .LINE_WIDTH(4),
    .ADDR_WIDTH(2)
  ) dut (
    .clk    (clk),
    .reset_p(reset_p),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs just after the edge, return mid-cycle for sampling.
  task automatic cyc(input logic rst, input logic v, input logic h, input logic vs,
                     input logic [7:0] d);
    @(posedge clk);
    #1;
    reset_p           = rst;
    bus.shiftin_valid = v;
    bus.shiftin_hs    = h;
    bus.shiftin_vs    = vs;
    bus.shiftin       = d;
    #4;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
  endtask

  task automatic test_reset;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'hAA);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'hAA);
    obs = {bus.taps1x, bus.taps0x, bus.shiftout, bus.tap1_ok, bus.tap0_ok, bus.overrun};
    exp_v = 27'd0;
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL reset_state: got %h expected %h", obs, exp_v);
    end
    gap(2);
  endtask

  task automatic test_frame_start;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'(1 + i));
      obs = {bus.taps1x, bus.taps0x, bus.shiftout, bus.tap1_ok, bus.tap0_ok, bus.overrun};
      exp_v = 27'd0;
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL first_line px%0d: got %h expected %h", i, obs, exp_v);
      end
    end
    gap(2);
    obs = {bus.taps1x, bus.taps0x, bus.shiftout, bus.tap1_ok, bus.tap0_ok, bus.overrun};
    exp_v = {8'd1, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0};
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL after_line0_gap: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_three_lines;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'(5 + i));
      obs = {bus.taps1x, bus.taps0x, bus.shiftout, bus.tap1_ok, bus.tap0_ok, bus.overrun};
      exp_v = {8'(1 + i), 8'd0, 8'd0, 1'b1, 1'b0, 1'b0};
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL line1 px%0d: got %h expected %h", i, obs, exp_v);
      end
    end
    gap(2);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'(9 + i));
      obs = {bus.taps1x, bus.taps0x, bus.shiftout, bus.tap1_ok, bus.tap0_ok, bus.overrun};
      exp_v = {8'(5 + i), 8'(1 + i), 8'(1 + i), 1'b1, 1'b1, 1'b0};
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL line2 px%0d: got %h expected %h", i, obs, exp_v);
      end
    end
    gap(2);
  endtask

  task automatic test_bubbles;
    logic       v_t  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] d_t  [6] = '{8'd13, 8'd0, 8'd0, 8'd14, 8'd15, 8'd16};
    logic [7:0] e1_t [6] = '{8'd9, 8'd10, 8'd10, 8'd10, 8'd11, 8'd12};
    logic [7:0] e0_t [6] = '{8'd5, 8'd6, 8'd6, 8'd6, 8'd7, 8'd8};
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, v_t[i], 1'b1, 1'b1, d_t[i]);
      obs = {bus.taps1x, bus.taps0x, bus.shiftout, bus.tap1_ok, bus.tap0_ok, bus.overrun};
      exp_v = {e1_t[i], e0_t[i], e0_t[i], 1'b1, 1'b1, 1'b0};
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL bubbles cyc%0d: got %h expected %h", i, obs, exp_v);
      end
    end
    gap(2);
  endtask

  task automatic test_overrun;
    logic [7:0] e1_t [6] = '{8'd13, 8'd14, 8'd15, 8'd16, 8'd0, 8'd0};
    logic [7:0] e0_t [6] = '{8'd9, 8'd10, 8'd11, 8'd12, 8'd0, 8'd0};
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'(17 + i));
      obs = {bus.taps1x, bus.taps0x, bus.shiftout, bus.tap1_ok, bus.tap0_ok, bus.overrun};
      exp_v = {e1_t[i], e0_t[i], e0_t[i], 1'b1, 1'b1, (i == 5)};
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL overrun px%0d: got %h expected %h", i, obs, exp_v);
      end
    end
    gap(1);
    obs = {bus.taps1x, bus.taps0x, bus.shiftout, bus.tap1_ok, bus.tap0_ok, bus.overrun};
    exp_v = {8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1};
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL overrun_sticky: got %h expected %h", obs, exp_v);
    end
    gap(1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'(23 + i));
      obs = {bus.taps1x, bus.taps0x, bus.shiftout, bus.tap1_ok, bus.tap0_ok, bus.overrun};
      exp_v = {8'(17 + i), 8'(13 + i), 8'(13 + i), 1'b1, 1'b1, 1'b1};
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL after_overrun px%0d: got %h expected %h", i, obs, exp_v);
      end
    end
    gap(2);
  endtask

  task automatic test_frame_boundary;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    obs = {bus.taps1x, bus.taps0x, bus.shiftout, bus.tap1_ok, bus.tap0_ok, bus.overrun};
    exp_v = 27'd0;
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL vs_low_clear: got %h expected %h", obs, exp_v);
    end
    gap(1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'(30 + i));
      obs = {bus.taps1x, bus.taps0x, bus.shiftout, bus.tap1_ok, bus.tap0_ok, bus.overrun};
      exp_v = 27'd0;
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL new_frame_line0 px%0d: got %h expected %h", i, obs, exp_v);
      end
    end
    gap(2);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'(34 + i));
      obs = {bus.taps1x, bus.taps0x, bus.shiftout, bus.tap1_ok, bus.tap0_ok, bus.overrun};
      exp_v = {8'(30 + i), 8'd0, 8'd0, 1'b1, 1'b0, 1'b0};
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL new_frame_line1 px%0d: got %h expected %h", i, obs, exp_v);
      end
    end
    gap(2);
  endtask

  task automatic test_reset_mid_line;
    logic [7:0] e1_t [4] = '{8'd43, 8'd44, 8'd36, 8'd37};
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'(40 + i));
      obs = {bus.taps1x, bus.taps0x, bus.shiftout, bus.tap1_ok, bus.tap0_ok, bus.overrun};
      exp_v = {8'(34 + i), 8'(30 + i), 8'(30 + i), 1'b1, 1'b1, 1'b0};
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL pre_reset px%0d: got %h expected %h", i, obs, exp_v);
      end
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'd42);
    obs = {bus.taps1x, bus.taps0x, bus.shiftout, bus.tap1_ok, bus.tap0_ok, bus.overrun};
    exp_v = {8'd36, 8'd32, 8'd32, 1'b1, 1'b1, 1'b0};
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL reset_between_edges: got %h expected %h", obs, exp_v);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'(43 + i));
      obs = {bus.taps1x, bus.taps0x, bus.shiftout, bus.tap1_ok, bus.tap0_ok, bus.overrun};
      exp_v = 27'd0;
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL post_reset px%0d: got %h expected %h", i, obs, exp_v);
      end
    end
    gap(2);
    obs = {bus.taps1x, bus.taps0x, bus.shiftout, bus.tap1_ok, bus.tap0_ok, bus.overrun};
    exp_v = {8'd43, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0};
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL post_reset_gap: got %h expected %h", obs, exp_v);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'(50 + i));
      obs = {bus.taps1x, bus.taps0x, bus.shiftout, bus.tap1_ok, bus.tap0_ok, bus.overrun};
      exp_v = {e1_t[i], 8'd0, 8'd0, 1'b1, 1'b0, 1'b0};
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL post_reset_line px%0d: got %h expected %h", i, obs, exp_v);
      end
    end
    gap(2);
  endtask

  initial begin
    bus.shiftin       = 8'd0;
    bus.shiftin_valid = 1'b0;
    bus.shiftin_hs    = 1'b0;
    bus.shiftin_vs    = 1'b0;
    test_reset();
    test_frame_start();
    test_three_lines();
    test_bubbles();
    test_overrun();
    test_frame_boundary();
    test_reset_mid_line();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
